// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: issue, read, write-back and PC bus of the scoreboarded register file
interface reg_file_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 4
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     set_dest;
    logic [ADDR_W-1:0]        set_dest_addr;
    logic                     set_base;
    logic [ADDR_W-1:0]        set_base_addr;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     upd_en;
    logic [ADDR_W-1:0]        upd_addr;
    logic [DATA_W-1:0]        upd_data;
    logic                     pc_we;
    logic [DATA_W-1:0]        pc_next;
    logic [DATA_W-1:0]        pc_out;
    logic [NUM_REGS-1:0]      pending;
    logic                     stall;

    modport master (
        output rd_en, rd_addr, set_dest, set_dest_addr, set_base, set_base_addr,
               wb_en, wb_addr, wb_data, upd_en, upd_addr, upd_data, pc_we, pc_next,
        input  rd_data, pc_out, pending, stall
    );
    modport slave (
        input  rd_en, rd_addr, set_dest, set_dest_addr, set_base, set_base_addr,
               wb_en, wb_addr, wb_data, upd_en, upd_addr, upd_data, pc_we, pc_next,
        output rd_data, pc_out, pending, stall
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with scoreboard, dual write-back forwarding, hazard stall and PC alias
module reg_file_sb #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 16,
    parameter int                ADDR_W   = 4,
    parameter int                NUM_RD   = 4,
    parameter int                PC_IDX   = 15,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [NUM_REGS-1:0] pending_q, pending_d, resolved, blocked;
    logic                wb_ok, upd_ok, dest_ok, base_ok, stall;
    logic [ADDR_W-1:0]   ra;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    always_comb begin
        wb_ok    = bus.wb_en && in_range(bus.wb_addr);
        upd_ok   = bus.upd_en && in_range(bus.upd_addr);
        dest_ok  = bus.set_dest && in_range(bus.set_dest_addr);
        base_ok  = bus.set_base && in_range(bus.set_base_addr);
        resolved = '0;
        if (wb_ok) resolved[bus.wb_addr] = 1'b1;
        if (upd_ok) resolved[bus.upd_addr] = 1'b1;
        blocked = pending_q & ~resolved;
        stall = (dest_ok && blocked[bus.set_dest_addr]) || (base_ok && blocked[bus.set_base_addr]) ||
                (dest_ok && base_ok && bus.set_dest_addr == bus.set_base_addr);
        bus.rd_data = '0;
        ra = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
            if (bus.rd_en[i] && ra != PC_A && in_range(ra) && blocked[ra]) stall = 1'b1;
            bus.rd_data[i*DATA_W +: DATA_W] = !bus.rd_en[i] || !in_range(ra) ? '0 :
                                              ra == PC_A                   ? pc_q :
                                              wb_ok && bus.wb_addr == ra   ? bus.wb_data :
                                              upd_ok && bus.upd_addr == ra ? bus.upd_data : regs_q[ra];
        end
    end

    // wb is applied after upd so it wins a same-address collision; sets follow clears so a new producer wins
    always_comb begin
        regs_d    = regs_q;
        pc_d      = bus.pc_we ? bus.pc_next : pc_q;
        pending_d = pending_q & ~resolved;
        if (!stall && dest_ok) pending_d[bus.set_dest_addr] = 1'b1;
        if (!stall && base_ok) pending_d[bus.set_base_addr] = 1'b1;
        if (upd_ok && bus.upd_addr == PC_A) pc_d = bus.upd_data;
        else if (upd_ok) regs_d[bus.upd_addr] = bus.upd_data;
        if (wb_ok && bus.wb_addr == PC_A) pc_d = bus.wb_data;
        else if (wb_ok) regs_d[bus.wb_addr] = bus.wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q    <= '{default: '0};
            pc_q      <= RESET_PC;
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    assign bus.stall   = stall;
    assign bus.pc_out  = pc_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against a behavioural model
module tb_reg_file_sb;
    localparam int DW = 32, NR = 16, AW = 4, NRD = 4, PCI = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD)) bus ();
    reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .PC_IDX(PCI), .RESET_PC(32'h0))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));

    logic [DW-1:0] m_reg [NR];
    logic [DW-1:0] m_pc;
    logic [NR-1:0] m_pend;
    int n_pass = 0, n_tot = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic m_reset();
        for (int r = 0; r < NR; r++) m_reg[r] = '0;
        m_pc = '0;
        m_pend = '0;
    endtask

    task automatic idle();
        bus.rd_en = '0; bus.rd_addr = '0;
        bus.set_dest = 0; bus.set_dest_addr = '0; bus.set_base = 0; bus.set_base_addr = '0;
        bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.upd_en = 0; bus.upd_addr = '0; bus.upd_data = '0;
        bus.pc_we = 0; bus.pc_next = '0;
    endtask

    task automatic rd(input int p, input int a);
        bus.rd_en[p] = 1'b1;
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic bit written(int a);
        return (bus.wb_en && int'(bus.wb_addr) == a) || (bus.upd_en && int'(bus.upd_addr) == a);
    endfunction

    function automatic bit waits_on(int a);
        return m_pend[a] && !written(a);
    endfunction

    function automatic bit exp_stall();
        bit s = 0;
        for (int i = 0; i < NRD; i++) begin
            int a = int'(bus.rd_addr[i*AW +: AW]);
            if (bus.rd_en[i] && a != PCI && waits_on(a)) s = 1;
        end
        if (bus.set_dest && waits_on(int'(bus.set_dest_addr))) s = 1;
        if (bus.set_base && waits_on(int'(bus.set_base_addr))) s = 1;
        if (bus.set_dest && bus.set_base && bus.set_dest_addr == bus.set_base_addr) s = 1;
        return s;
    endfunction

    function automatic logic [DW-1:0] exp_read(int i);
        int a = int'(bus.rd_addr[i*AW +: AW]);
        if (!bus.rd_en[i]) return '0;
        if (a == PCI) return m_pc;
        if (bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
        if (bus.upd_en && int'(bus.upd_addr) == a) return bus.upd_data;
        return m_reg[a];
    endfunction

    task automatic model_clock(input bit s);
        logic [DW-1:0] npc = bus.pc_we ? bus.pc_next : m_pc;
        for (int r = 0; r < NR; r++) if (written(r)) m_pend[r] = 1'b0;
        if (!s && bus.set_dest) m_pend[bus.set_dest_addr] = 1'b1;
        if (!s && bus.set_base) m_pend[bus.set_base_addr] = 1'b1;
        if (bus.upd_en && int'(bus.upd_addr) == PCI) npc = bus.upd_data;
        else if (bus.upd_en) m_reg[bus.upd_addr] = bus.upd_data;
        if (bus.wb_en && int'(bus.wb_addr) == PCI) npc = bus.wb_data;
        else if (bus.wb_en) m_reg[bus.wb_addr] = bus.wb_data;
        m_pc = npc;
    endtask

    task automatic step(input string tag);
        bit s;
        @(negedge clk);
        s = exp_stall();
        chk({tag, ".stall"}, {31'b0, bus.stall}, {31'b0, s});
        for (int i = 0; i < NRD; i++) chk($sformatf("%s.rd%0d", tag, i), bus.rd_data[i*DW +: DW], exp_read(i));
        model_clock(s);
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, bus.pc_out, m_pc);
        chk({tag, ".pend"}, {16'b0, bus.pending}, {16'b0, m_pend});
        idle();
    endtask

    initial begin
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.pc", bus.pc_out, 32'h0);
        chk("rst.pend", {16'b0, bus.pending}, 32'h0);
        chk("rst.stall", {31'b0, bus.stall}, 32'h0);

        bus.pc_we = 1; bus.pc_next = 32'd4;
        step("pc_load");
        chk("pc_load.val", bus.pc_out, 32'd4);
        rd(0, 15); rd(1, 0); rd(2, 1); rd(3, 14);
        #1 chk("pc_read.r15", bus.rd_data[0 +: DW], 32'd4);
        chk("pc_read.r0", bus.rd_data[DW +: DW], 32'd0);
        step("pc_read");

        bus.set_dest = 1; bus.set_dest_addr = 4'd12;
        step("raw_issue");
        rd(0, 12);
        #1 chk("raw.stall_hi", {31'b0, bus.stall}, 32'd1);
        step("raw_wait1");
        rd(0, 12);
        step("raw_wait2");
        rd(0, 12); bus.wb_en = 1; bus.wb_addr = 4'd12; bus.wb_data = 32'd5;
        #1 chk("raw_wb.stall", {31'b0, bus.stall}, 32'd0);
        chk("raw_wb.fwd", bus.rd_data[0 +: DW], 32'd5);
        step("raw_wb");
        rd(0, 12);
        #1 chk("raw_after.rd", bus.rd_data[0 +: DW], 32'd5);
        step("raw_after");

        bus.set_dest = 1; bus.set_dest_addr = 4'd12; bus.set_base = 1; bus.set_base_addr = 4'd4;
        step("dual_issue");
        chk("dual_issue.pend", {16'b0, bus.pending}, 32'h1010);
        rd(0, 12); rd(1, 4);
        bus.wb_en = 1; bus.wb_addr = 4'd12; bus.wb_data = 32'd5;
        bus.upd_en = 1; bus.upd_addr = 4'd4; bus.upd_data = 32'd11;
        step("dual_wb");
        rd(0, 12); rd(1, 4);
        #1 chk("dual_after.r12", bus.rd_data[0 +: DW], 32'd5);
        chk("dual_after.r4", bus.rd_data[DW +: DW], 32'd11);
        step("dual_after");

        bus.wb_en = 1; bus.wb_addr = 4'd7; bus.wb_data = 32'd5;
        bus.upd_en = 1; bus.upd_addr = 4'd7; bus.upd_data = 32'd11;
        step("collide");
        rd(0, 7);
        #1 chk("collide.r7", bus.rd_data[0 +: DW], 32'd5);
        step("collide_rd");

        bus.wb_en = 1; bus.wb_addr = 4'd15; bus.wb_data = 32'd8;
        bus.pc_we = 1; bus.pc_next = 32'd20;
        step("pc_prio");
        chk("pc_prio.val", bus.pc_out, 32'd8);

        bus.set_dest = 1; bus.set_dest_addr = 4'd3;
        step("waw_issue");
        bus.set_dest = 1; bus.set_dest_addr = 4'd3;
        #1 chk("waw.stall", {31'b0, bus.stall}, 32'd1);
        step("waw");
        chk("waw.pend", {16'b0, bus.pending}, 32'h0008);
        bus.set_dest = 1; bus.set_dest_addr = 4'd3; bus.wb_en = 1; bus.wb_addr = 4'd3; bus.wb_data = 32'd9;
        #1 chk("waw_wb.stall", {31'b0, bus.stall}, 32'd0);
        step("waw_wb");
        chk("waw_wb.pend", {16'b0, bus.pending}, 32'h0008);

        for (int c = 0; c < 400; c++) begin
            bus.rd_en = 4'($urandom);
            bus.rd_addr = 16'($urandom);
            bus.set_dest = ($urandom_range(3) == 0);
            bus.set_dest_addr = 4'($urandom);
            bus.set_base = ($urandom_range(5) == 0);
            bus.set_base_addr = 4'($urandom);
            bus.wb_en = 1'($urandom_range(1));
            bus.wb_addr = 4'($urandom);
            bus.wb_data = $urandom;
            bus.upd_en = ($urandom_range(2) == 0);
            bus.upd_addr = 4'($urandom);
            bus.upd_data = $urandom;
            bus.pc_we = ($urandom_range(3) == 0);
            bus.pc_next = $urandom;
            step("rnd");
        end

        reset = 1'b1;
        #1 reset = 1'b0;
        m_reset();
        bus.set_dest = 1; bus.set_dest_addr = 4'd12; bus.set_base = 1; bus.set_base_addr = 4'd4;
        bus.wb_en = 1; bus.wb_addr = 4'd5; bus.wb_data = 32'hdead_beef;
        bus.pc_we = 1; bus.pc_next = 32'h40;
        step("ar_setup");
        chk("ar_setup.pend", {16'b0, bus.pending}, 32'h1010);
        #2 reset = 1'b1;
        m_reset();
        #1 chk("ar.pend", {16'b0, bus.pending}, 32'h0);
        chk("ar.pc", bus.pc_out, 32'h0);
        for (int b = 0; b < NR; b += NRD) begin
            for (int j = 0; j < NRD; j++) rd(j, b + j);
            #1 chk($sformatf("ar.stall%0d", b), {31'b0, bus.stall}, 32'd0);
            for (int j = 0; j < NRD; j++) chk($sformatf("ar.r%0d", b + j), bus.rd_data[j*DW +: DW], 32'h0);
        end
        idle();
        @(posedge clk);
        #1 reset = 1'b0;
        rd(0, 5); rd(1, 12);
        step("ar_post");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
